// File: rtl/tlc_timed_ctrl.sv
// Timer-driven highway/farm-road traffic light controller with latched sensor requests.
// Optional night-flash override is enabled by defining TLC_FLASH_EN.
module tlc_timed_ctrl #(
    parameter int CNT_W       = 8,
    parameter int T_GREEN_MIN = 20,
    parameter int T_YELLOW    = 4,
    parameter int T_LEFT      = 10,
    parameter int T_FARM      = 12,
    parameter int T_ALLRED    = 2
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       TICK,
    input  logic       HS,
    input  logic       FS,
`ifdef TLC_FLASH_EN
    input  logic       FLASH,
`endif
    output logic       HGREEN,
    output logic       HYELLOW,
    output logic       HLEFT,
    output logic       HRED,
    output logic       FGREEN,
    output logic       FYELLOW,
    output logic       FLEFT,
    output logic       FRED,
    output logic [2:0] PHASE
);

    typedef enum logic [2:0] {
        ST_HG  = 3'd0,
        ST_HY  = 3'd1,
        ST_HL  = 3'd2,
        ST_HLY = 3'd3,
        ST_AR  = 3'd4,
        ST_FG  = 3'd5,
        ST_FY  = 3'd6,
        ST_AR2 = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] LIM_GMIN   = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] LIM_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LIM_LEFT   = CNT_W'(T_LEFT - 1);
    localparam logic [CNT_W-1:0] LIM_FARM   = CNT_W'(T_FARM - 1);
    localparam logic [CNT_W-1:0] LIM_ALLRED = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] TMR_MAX    = {CNT_W{1'b1}};
    localparam logic [7:0]       LAMPS_RST  = 8'b1000_0001;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             hs_req_q, hs_req_d;
    logic             fs_req_q, fs_req_d;
    logic [7:0]       lamps_q, lamps_d;
    logic             hold_s;
    logic             restart_s;
`ifdef TLC_FLASH_EN
    logic             flash_q, flash_d;
    logic             blink_q, blink_d;
`endif

    // Lamp bit order: {HGREEN, HYELLOW, HLEFT, HRED, FGREEN, FYELLOW, FLEFT, FRED}
    function automatic logic [7:0] lamp_decode(input state_t s);
        logic [7:0] l;
        case (s)
            ST_HG:   l = 8'b1000_0001;
            ST_HY:   l = 8'b0100_0001;
            ST_HL:   l = 8'b0010_0001;
            ST_HLY:  l = 8'b0100_0001;
            ST_AR:   l = 8'b0001_0001;
            ST_FG:   l = 8'b0001_1010;
            ST_FY:   l = 8'b0001_0100;
            ST_AR2:  l = 8'b0001_0001;
            default: l = 8'b0001_0001;
        endcase
        return l;
    endfunction

    // Next-state, timer, request latch and lamp computation
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        hold_s    = 1'b0;
        restart_s = 1'b0;
`ifdef TLC_FLASH_EN
        flash_d = FLASH;
        if (!flash_q && FLASH) begin
            blink_d = 1'b1;
        end else if (flash_q && TICK) begin
            blink_d = ~blink_q;
        end else begin
            blink_d = blink_q;
        end
        if (FLASH) begin
            hold_s = 1'b1;
        end else if (flash_q) begin
            restart_s = 1'b1;
        end else begin
            hold_s = 1'b0;
        end
`endif
        if (restart_s) begin
            state_d = ST_AR2;
        end else if (TICK && !hold_s) begin
            case (state_q)
                ST_HG:   if ((timer_q >= LIM_GMIN) && (hs_req_q || fs_req_q)) state_d = ST_HY;
                         else state_d = ST_HG;
                ST_HY:   if (timer_q == LIM_YELLOW) state_d = hs_req_q ? ST_HL : ST_AR;
                         else state_d = ST_HY;
                ST_HL:   if (timer_q == LIM_LEFT) state_d = ST_HLY;
                         else state_d = ST_HL;
                ST_HLY:  if (timer_q == LIM_YELLOW) state_d = ST_AR;
                         else state_d = ST_HLY;
                ST_AR:   if (timer_q == LIM_ALLRED) state_d = fs_req_q ? ST_FG : ST_HG;
                         else state_d = ST_AR;
                ST_FG:   if (timer_q == LIM_FARM) state_d = ST_FY;
                         else state_d = ST_FG;
                ST_FY:   if (timer_q == LIM_YELLOW) state_d = ST_AR2;
                         else state_d = ST_FY;
                ST_AR2:  if (timer_q == LIM_ALLRED) state_d = ST_HG;
                         else state_d = ST_AR2;
                default: state_d = ST_HG;
            endcase
        end else begin
            state_d = state_q;
        end

        if (restart_s || (state_d != state_q)) begin
            timer_d = {CNT_W{1'b0}};
        end else if (TICK && !hold_s && (timer_q != TMR_MAX)) begin
            timer_d = timer_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            timer_d = timer_q;
        end

        // Clearing on entry into the served phase beats a simultaneous set
        hs_req_d = hs_req_q || (HS && (state_q != ST_HL));
        if ((state_d == ST_HL) && (state_q != ST_HL)) begin
            hs_req_d = 1'b0;
        end else begin
            hs_req_d = hs_req_d;
        end
        fs_req_d = fs_req_q || (FS && (state_q != ST_FG));
        if ((state_d == ST_FG) && (state_q != ST_FG)) begin
            fs_req_d = 1'b0;
        end else begin
            fs_req_d = fs_req_d;
        end

`ifdef TLC_FLASH_EN
        if (flash_d) begin
            lamps_d = {1'b0, blink_d, 5'b0_0000, blink_d};
        end else begin
            lamps_d = lamp_decode(state_d);
        end
`else
        lamps_d = lamp_decode(state_d);
`endif
    end

    // State, timer, request and output registers
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_HG;
            timer_q  <= {CNT_W{1'b0}};
            hs_req_q <= 1'b0;
            fs_req_q <= 1'b0;
            lamps_q  <= LAMPS_RST;
`ifdef TLC_FLASH_EN
            flash_q  <= 1'b0;
            blink_q  <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            hs_req_q <= hs_req_d;
            fs_req_q <= fs_req_d;
            lamps_q  <= lamps_d;
`ifdef TLC_FLASH_EN
            flash_q  <= flash_d;
            blink_q  <= blink_d;
`endif
        end
    end

    assign {HGREEN, HYELLOW, HLEFT, HRED, FGREEN, FYELLOW, FLEFT, FRED} = lamps_q;
    assign PHASE = state_q;

endmodule
